// File: rtl/quadrilatero_mac_seq.sv
// quadrilatero_mac_seq: sequences one FP32 dot-product job onto an external
// FP32 MAC unit, one operation in flight at a time.
// Optional feature: define QUADRILATERO_MAC_SEQ_WATCHDOG_EN to add a WAIT-state
// timeout that pulses err_o and returns the accumulator seen so far.
module quadrilatero_mac_seq #(
   parameter int LEN_W    = 8,
   parameter int WDOG_CYC = 15
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [31:0]      acc_init_i,
   output logic             busy_o,
   input  logic             op_valid_i,
   output logic             op_ready_o,
   input  logic [31:0]      data_i,
   input  logic [31:0]      weight_i,
   output logic [31:0]      mac_data_o,
   output logic [31:0]      mac_weight_o,
   output logic [31:0]      mac_acc_o,
   output logic             mac_valid_o,
   input  logic             mac_finished_i,
   input  logic [31:0]      mac_acc_i,
   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [31:0]      res_o,
   output logic             err_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Reject degenerate configurations at elaboration time.
   if (LEN_W < 1) begin : g_chk_len
      $error("quadrilatero_mac_seq: LEN_W must be >= 1");
   end
   if (WDOG_CYC < 1) begin : g_chk_wdog
      $error("quadrilatero_mac_seq: WDOG_CYC must be >= 1");
   end

   state_t           r_state;
   logic [31:0]      r_acc;
   logic [LEN_W-1:0] r_cnt;
   logic [31:0]      r_mac_data;
   logic [31:0]      r_mac_weight;
   logic [31:0]      r_mac_acc;
   logic             r_mac_valid;

`ifdef QUADRILATERO_MAC_SEQ_WATCHDOG_EN
   localparam int WDOG_W = (WDOG_CYC < 2) ? 1 : $clog2(WDOG_CYC + 1);
   logic [WDOG_W-1:0] r_wdog;
   logic              r_err;
`endif

   // Sequencer FSM: job latch, operand issue, MAC wait, result hand-off.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_acc        <= '0;
         r_cnt        <= '0;
         r_mac_data   <= '0;
         r_mac_weight <= '0;
         r_mac_acc    <= '0;
         r_mac_valid  <= 1'b0;
`ifdef QUADRILATERO_MAC_SEQ_WATCHDOG_EN
         r_wdog       <= '0;
         r_err        <= 1'b0;
`endif
      end else begin
         // issue and error strobes are single-cycle pulses
         r_mac_valid <= 1'b0;
`ifdef QUADRILATERO_MAC_SEQ_WATCHDOG_EN
         r_err       <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_acc   <= acc_init_i;
                  r_cnt   <= len_i;
                  r_state <= (len_i == '0) ? S_DONE : S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (op_valid_i) begin
                  r_mac_data   <= data_i;
                  r_mac_weight <= weight_i;
                  r_mac_acc    <= r_acc;
                  r_mac_valid  <= 1'b1;
                  r_state      <= S_WAIT;
`ifdef QUADRILATERO_MAC_SEQ_WATCHDOG_EN
                  r_wdog       <= '0;
`endif
               end
            end
            S_WAIT: begin
               if (mac_finished_i) begin
                  // cnt is nonzero here, so the decrement never wraps
                  r_acc   <= mac_acc_i;
                  r_cnt   <= r_cnt - LEN_W'(1);
                  r_state <= (r_cnt == LEN_W'(1)) ? S_DONE : S_ISSUE;
               end
`ifdef QUADRILATERO_MAC_SEQ_WATCHDOG_EN
               else if (r_wdog == WDOG_W'(WDOG_CYC - 1)) begin
                  // give up on the MAC; deliver whatever has accumulated
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_wdog  <= r_wdog + WDOG_W'(1);
               end
`endif
            end
            S_DONE: begin
               if (res_ready_i) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy_o       = (r_state != S_IDLE);
   assign op_ready_o   = (r_state == S_ISSUE);
   assign res_valid_o  = (r_state == S_DONE);
   assign res_o        = r_acc;
   assign mac_data_o   = r_mac_data;
   assign mac_weight_o = r_mac_weight;
   assign mac_acc_o    = r_mac_acc;
   assign mac_valid_o  = r_mac_valid;

`ifdef QUADRILATERO_MAC_SEQ_WATCHDOG_EN
   assign err_o = r_err;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: doc/quadrilatero_mac_seq.md
QUADRILATERO_MAC_SEQ -- requirements
Module: quadrilatero_mac_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 8, width of the dot-product length field.
REQ-002 SHALL have parameter WDOG_CYC, default 15, maximum number of WAIT cycles before timeout (used only with the watchdog).
REQ-003 SHALL have port clk_i  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start_i  input  1  job request, sampled only in IDLE.
REQ-006 SHALL have port len_i  input  LEN_W  number of MAC steps in the job.
REQ-007 SHALL have port acc_init_i  input  32  initial FP32 accumulator.
REQ-008 SHALL have port busy_o  output  1  high whenever state != IDLE.
REQ-009 SHALL have port op_valid_i / op_ready_o  input/output  1/1  operand-stream handshake.
REQ-010 SHALL have port data_i, weight_i  input  32 each  FP32 operand pair.
REQ-011 SHALL have port mac_data_o, mac_weight_o, mac_acc_o  output  32 each  registered operands to the FP32 MAC.
REQ-012 SHALL have port mac_valid_o  output  1  one-cycle issue pulse to the MAC.
REQ-013 SHALL have port mac_finished_i / mac_acc_i  input  1/32  MAC completion pulse and result.
REQ-014 SHALL have port res_valid_o / res_ready_i / res_o  output/input/output  1/1/32  final-result handshake.
REQ-015 SHALL have port err_o  output  1  watchdog timeout pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-017 In IDLE with start_i=1, the block SHALL latch acc_q<=acc_init_i and cnt<=len_i, then go to DONE if len_i==0, else to ISSUE.
REQ-018 In ISSUE, op_ready_o SHALL be 1 (0 in all other states); on op_valid_i&op_ready_o the block SHALL register mac_data_o<=data_i, mac_weight_o<=weight_i, mac_acc_o<=acc_q, pulse mac_valid_o high for exactly the next cycle, and go to WAIT.
REQ-019 The block SHALL keep at most one MAC operation outstanding: no issue occurs until mac_finished_i is seen in WAIT.
REQ-020 In WAIT with mac_finished_i=1, the block SHALL set acc_q<=mac_acc_i and cnt<=cnt-1, then go to DONE if cnt==1, else to ISSUE.
REQ-021 mac_finished_i asserted outside WAIT SHALL be ignored.
REQ-022 In DONE, res_valid_o SHALL be 1 and res_o SHALL equal acc_q, both stable until res_ready_i; on res_ready_i the block SHALL go to IDLE.
REQ-023 start_i outside IDLE SHALL be ignored; a new job SHALL be accepted no earlier than the cycle after the DONE handshake.
REQ-024 Minimum latency SHALL be start -> ISSUE 1 cycle, operand handshake -> mac_valid_o 1 cycle, mac_finished_i -> next ISSUE or DONE 1 cycle.
REQ-025 cnt SHALL be an unsigned LEN_W-bit counter and SHALL never wrap; len_i=2^LEN_W-1 SHALL perform exactly that many steps.
REQ-026 The block SHALL perform no FP arithmetic; acc_q SHALL only ever take acc_init_i or mac_acc_i.

Reset
REQ-027 While rst_i=1, in any state, the block SHALL asynchronously force state=IDLE, acc_q=0, cnt=0, all outputs=0, and mac_valid_o=0.
REQ-028 A reset mid-job SHALL discard the job; a mac_finished_i arriving after reset SHALL be ignored (REQ-021).

Configuration
REQ-029 With QUADRILATERO_MAC_SEQ_WATCHDOG_EN defined, a counter SHALL clear on WAIT entry and increment on each WAIT cycle without mac_finished_i.
REQ-030 With the macro defined, reaching WDOG_CYC SHALL pulse err_o for 1 cycle and move the block to DONE with acc_q unchanged.
REQ-031 Without the macro, no watchdog logic SHALL exist, err_o SHALL be tied to 0, and WAIT SHALL persist indefinitely.

Verification
REQ-032 Bench SHALL cover: model MAC with 1-cycle latency, len=3, acc_init=0x00000000, pairs (0x3F800000,0x40000000), (0x40000000,0x40000000), (0x40400000,0x3F800000) -> res_o=0x41100000 (9.0), exactly 3 mac_valid_o pulses.
REQ-033 Bench SHALL cover: len=0, acc_init=0x40400000 -> DONE one cycle after start, res_o=0x40400000, zero mac_valid_o pulses.
REQ-034 Bench SHALL cover: res_ready_i held 0 for 5 cycles -> res_valid_o and res_o stable; start_i pulsed during DONE -> ignored.
REQ-035 Bench SHALL cover: rst_i asserted in WAIT, then a late mac_finished_i -> state IDLE, busy_o=0, all outputs 0, no result produced.
REQ-036 Bench SHALL cover, with the watchdog enabled: MAC never finishes, WDOG_CYC=15 -> err_o pulses after 15 WAIT cycles, then res_valid_o=1 with the last acc_q.
REQ-037 Bench SHALL cover: op_valid_i with random gaps, len=255 -> 255 issues, cnt reaches 0 without wrap, final result matches the reference model.
